// File: rtl/cgra_config_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cgra_config_sequencer
//
// Streams a fixed-length load of (address, data) configuration words from a
// valid/ready source onto the CGRA fabric config bus. Each word is strobed for
// one cycle, then held stable for HOLD_CYCLES cycles. When the load ends the
// bus is parked on PARK_ADDR and config_done is raised so datapath traffic can
// start. A source that stalls for TIMEOUT cycles aborts the load with error.
//
// Optional feature (macro CFG_CHECKSUM_EN): running sum of accepted data words,
// compared with expected_sum when a load completes normally.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, num_words        load request pulse and its word count
//   in_valid/in_ready       source handshake
//   in_addr, in_data        source config word
//   config_addr/data/valid  fabric config bus and its one-cycle strobe
//   busy                    load in progress
//   config_done             load finished (level, until next accepted start)
//   error                   load aborted or failed (level)
//   expected_sum, sum_out   checksum reference / running sum (CFG_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module cgra_config_sequencer #(
    parameter int unsigned    AW          = 32,
    parameter int unsigned    DW          = 32,
    parameter int unsigned    CW          = 16,
    parameter int unsigned    HOLD_CYCLES = 2,
    parameter int unsigned    TIMEOUT     = 1024,
    parameter logic [AW-1:0]  PARK_ADDR   = {AW{1'b1}}
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] num_words,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
`ifdef CFG_CHECKSUM_EN
    input  logic [DW-1:0] expected_sum,
    output logic [DW-1:0] sum_out,
`endif
    output logic [AW-1:0] config_addr,
    output logic [DW-1:0] config_data,
    output logic          config_valid,
    output logic          busy,
    output logic          config_done,
    output logic          error
);

    // Counter sizing; the max() guards keep widths legal for TIMEOUT=1 and
    // HOLD_CYCLES of 0 or 1.
    localparam int unsigned TMO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int unsigned TW        = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned HW        = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef CFG_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] exp_q, exp_d;
`endif

    // Shared decode used by both the FSM and the datapath.
    logic start_ok, accept, tmo_hit, hold_end, more_words, enter_done;

    assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign accept     = (state_q == S_WAIT) && in_valid;
    assign tmo_hit    = (state_q == S_WAIT) && !in_valid && (tmo_q == TW'(TMO_LAST));
    assign hold_end   = (hold_q == HW'(HOLD_LAST));
    assign more_words = (remaining_q != '0);
    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) state_d = (num_words == '0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (accept)       state_d = S_ISSUE;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_ISSUE: begin
                if (HOLD_CYCLES > 0) state_d = S_HOLD;
                else                 state_d = more_words ? S_WAIT : S_DONE;
            end
            S_HOLD: begin
                if (hold_end) state_d = more_words ? S_WAIT : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready     = (state_q == S_WAIT);
        config_valid = (state_q == S_ISSUE);
        busy         = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_HOLD);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        remaining_d = remaining_q;
        tmo_d       = tmo_q;
        hold_d      = hold_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        err_d       = err_q;
`ifdef CFG_CHECKSUM_EN
        sum_d       = sum_q;
        exp_d       = exp_q;
`endif
        if (start_ok) begin
            // A zero-length load completes at once; there is nothing to
            // checksum, so error stays clear for it.
            remaining_d = num_words;
            tmo_d       = '0;
            done_d      = (num_words == '0);
            err_d       = 1'b0;
`ifdef CFG_CHECKSUM_EN
            sum_d       = '0;
            exp_d       = expected_sum;
`endif
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (accept) begin
                        addr_d = in_addr;
                        data_d = in_data;
                        tmo_d  = '0;
                        if (more_words) remaining_d = remaining_q - CW'(1);
`ifdef CFG_CHECKSUM_EN
                        sum_d  = sum_q + in_data;
`endif
                    end else if (!tmo_hit) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_ISSUE: hold_d = '0;
                S_HOLD:  hold_d = hold_q + HW'(1);
                default: ;
            endcase

            if (enter_done) begin
                addr_d = PARK_ADDR;
                data_d = '0;
                done_d = 1'b1;
                err_d  = tmo_hit;
`ifdef CFG_CHECKSUM_EN
                if (!tmo_hit) err_d = (sum_q != exp_q);
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            tmo_q       <= '0;
            hold_q      <= '0;
            addr_q      <= PARK_ADDR;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            sum_q       <= '0;
            exp_q       <= '0;
`endif
        end else begin
            remaining_q <= remaining_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CFG_CHECKSUM_EN
            sum_q       <= sum_d;
            exp_q       <= exp_d;
`endif
        end
    end

    assign config_addr = addr_q;
    assign config_data = data_q;
    assign config_done = done_q;
    assign error       = err_q;
`ifdef CFG_CHECKSUM_EN
    assign sum_out     = sum_q;
`endif

endmodule

// File: tb/tb_cgra_config_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cgra_config_sequencer
//
// Behavioural model: a load is a list of pending words plus a "gap" countdown
// (cycles until the bus may take the next word) and an idle count for the
// source stall limit. The model is compared against the DUT on every
// negative clock edge; directed sections add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cgra_config_sequencer;

    localparam int          CW   = 16;
    localparam int          HOLD = 2;
    localparam int          TMO  = 16;
    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [31:0]   in_addr   = '0;
    logic [31:0]   in_data   = '0;
    logic [31:0]   config_addr, config_data;
    logic          config_valid, busy, config_done, error;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]   expected_sum = '0;
    logic [31:0]   sum_out;
`endif

    always #5 clk = ~clk;

    cgra_config_sequencer #(
        .AW(32), .DW(32), .CW(CW),
        .HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .PARK_ADDR(PARK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .num_words    (num_words),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
`ifdef CFG_CHECKSUM_EN
        .expected_sum (expected_sum),
        .sum_out      (sum_out),
`endif
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_valid (config_valid),
        .busy         (busy),
        .config_done  (config_done),
        .error        (error)
    );

    // ------------------------------------------------------------------ check
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    bit          m_act, m_valid, m_ready, m_done, m_err, m_acc;
    int          m_rem, m_idle, m_gap;
    logic [31:0] m_addr = PARK, m_data = '0, m_sum = '0, m_exp = '0;

    task automatic m_finish(input bit timed_out);
        m_act  = 1'b0;
        m_done = 1'b1;
        m_addr = PARK;
        m_data = '0;
        m_err  = timed_out;
`ifdef CFG_CHECKSUM_EN
        if (!timed_out) m_err = (m_sum != m_exp);
`endif
    endtask

    task automatic m_reset();
        m_act = 0; m_valid = 0; m_ready = 0; m_done = 0; m_err = 0;
        m_rem = 0; m_idle = 0; m_gap = 0;
        m_addr = PARK; m_data = '0; m_sum = '0; m_exp = '0;
    endtask

    // One clock of the model: inputs are those seen at this rising edge, and
    // the m_* outputs describe the cycle that follows it.
    task automatic m_step();
        m_acc   = m_ready && in_valid;
        m_valid = 1'b0;
        if (start && !m_act) begin
            m_rem  = int'(num_words);
            m_done = (num_words == '0);
            m_err  = 1'b0;
            m_sum  = '0;
`ifdef CFG_CHECKSUM_EN
            m_exp  = expected_sum;
`endif
            m_act  = (num_words != '0);
            m_idle = 0;
            m_gap  = 0;
        end else if (m_act) begin
            if (m_acc) begin
                m_addr  = in_addr;
                m_data  = in_data;
                m_rem   = m_rem - 1;
                m_idle  = 0;
                m_valid = 1'b1;
                m_gap   = 1 + HOLD;
                m_sum   = m_sum + in_data;
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
                if (m_gap == 0 && m_rem == 0) m_finish(1'b0);
            end else if (m_idle == TMO - 1) begin
                m_finish(1'b1);
            end else begin
                m_idle = m_idle + 1;
            end
        end
        m_ready = m_act && (m_gap == 0) && (m_rem > 0);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else          m_step();
    end

    // ------------------------------------------------- compare + source driver
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } word_t;

    word_t       src_q[$];
    int          valid_pct  = 100;
    bit          hs_pending = 1'b0;
    bit          chk_en     = 1'b0;
    bit          prev_done  = 1'b0;
    int          ncyc       = 0;
    int          done_rise  = -1;
    int          s_cyc[$];
    logic [31:0] s_addr[$];
    logic [31:0] s_data[$];

    task automatic compare_cycle();
        ncyc++;
        if (chk_en && reset_n) begin
            check("in_ready",     64'(in_ready),     64'(m_ready));
            check("config_valid", 64'(config_valid), 64'(m_valid));
            check("busy",         64'(busy),         64'(m_act));
            check("config_done",  64'(config_done),  64'(m_done));
            check("error",        64'(error),        64'(m_err));
            check("config_addr",  64'(config_addr),  64'(m_addr));
            check("config_data",  64'(config_data),  64'(m_data));
`ifdef CFG_CHECKSUM_EN
            check("sum_out",      64'(sum_out),      64'(m_sum));
`endif
            if (config_valid) begin
                s_cyc.push_back(ncyc);
                s_addr.push_back(config_addr);
                s_data.push_back(config_data);
            end
            if (config_done && !prev_done) done_rise = ncyc;
        end
        prev_done = config_done;
    endtask

    task automatic drive_source();
        if (hs_pending && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            in_valid = 1'b1;
            in_addr  = src_q[0].a;
            in_data  = src_q[0].d;
        end else begin
            in_valid = 1'b0;
            in_addr  = $urandom;
            in_data  = $urandom;
        end
        hs_pending = in_valid && in_ready && reset_n;
    endtask

    always @(negedge clk) begin
        compare_cycle();
        drive_source();
    end

    // ---------------------------------------------------------------- helpers
    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        word_t w;
        w.a = a;
        w.d = d;
        src_q.push_back(w);
    endtask

    task automatic clear_logs();
        s_cyc.delete();
        s_addr.delete();
        s_data.delete();
        done_rise = -1;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start     = 1'b1;
        num_words = CW'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while ((m_act || busy) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 64'(m_act || busy), 64'd0);
    endtask

    task automatic wait_strobes(input string name, input int n, input int budget);
        int i = 0;
        while (s_cyc.size() < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(name, 64'(s_cyc.size() >= n), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------- test
    int          nw, sup;
    logic [31:0] ssum, ra, rd;

    initial begin
        // Power-on reset and reset values.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clk);
        #1;
        check("rst_addr",     64'(config_addr),  64'hFFFF_FFFF);
        check("rst_data",     64'(config_data),  64'd0);
        check("rst_valid",    64'(config_valid), 64'd0);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_done",     64'(config_done),  64'd0);
        check("rst_error",    64'(error),        64'd0);
        check("rst_in_ready", 64'(in_ready),     64'd0);

        // Three words, source always valid: strobes 4 cycles apart.
        src_q.delete();
        valid_pct = 100;
        push_word(32'h0000_0001, 32'hA);
        push_word(32'h0000_0002, 32'hB);
        push_word(32'h0000_0103, 32'hC);
        clear_logs();
        pulse_start(3);
        wait_idle("t1_bound", 200);
        #1;
        check("t1_strobes", 64'(s_cyc.size()), 64'd3);
        if (s_cyc.size() == 3) begin
            check("t1_gap0",  64'(s_cyc[1] - s_cyc[0]), 64'd4);
            check("t1_gap1",  64'(s_cyc[2] - s_cyc[1]), 64'd4);
            check("t1_addr0", 64'(s_addr[0]), 64'h1);
            check("t1_addr1", 64'(s_addr[1]), 64'h2);
            check("t1_addr2", 64'(s_addr[2]), 64'h103);
            check("t1_data0", 64'(s_data[0]), 64'hA);
            check("t1_data1", 64'(s_data[1]), 64'hB);
            check("t1_data2", 64'(s_data[2]), 64'hC);
            check("t1_done_cyc", 64'(done_rise), 64'(s_cyc[2] + 3));
        end
        check("t1_done",  64'(config_done), 64'd1);
        check("t1_error", 64'(error),       64'd0);
        check("t1_park",  64'(config_addr), 64'hFFFF_FFFF);

        // Zero-word load: done next cycle, no strobe, never busy.
        apply_reset();
        src_q.delete();
        clear_logs();
        pulse_start(0);
        #1;
        check("t2_done", 64'(config_done), 64'd1);
        check("t2_busy", 64'(busy),        64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t2_busy_later", 64'(busy),         64'd0);
        check("t2_no_strobe",  64'(s_cyc.size()), 64'd0);

        // Source stalls after one of two words: timeout abort.
        apply_reset();
        src_q.delete();
        push_word(32'h0000_0200, 32'h55);
        clear_logs();
        pulse_start(2);
        wait_idle("t3_bound", 300);
        #1;
        check("t3_strobes", 64'(s_cyc.size()), 64'd1);
        if (s_cyc.size() == 1) check("t3_done_cyc", 64'(done_rise), 64'(s_cyc[0] + 19));
        check("t3_error", 64'(error),       64'd1);
        check("t3_done",  64'(config_done), 64'd1);
        check("t3_park",  64'(config_addr), 64'hFFFF_FFFF);
        check("t3_data",  64'(config_data), 64'd0);

        // Four-word load with a stray start during HOLD; then a fresh load.
        src_q.delete();
        for (int k = 0; k < 4; k++) push_word(32'h0000_0300 + k, 32'h1000 + k);
        clear_logs();
        pulse_start(4);
        #1;
        check("t4_done_clr",  64'(config_done), 64'd0);
        check("t4_error_clr", 64'(error),       64'd0);
        wait_strobes("t4_first", 1, 50);
        pulse_start(7);
        wait_idle("t4_bound", 300);
        #1;
        check("t4_strobes", 64'(s_cyc.size()), 64'd4);
        check("t4_done",    64'(config_done),  64'd1);
        check("t4_error",   64'(error),        64'd0);
        push_word(32'h0000_0400, 32'h77);
        pulse_start(1);
        #1;
        check("t4b_done_clr", 64'(config_done), 64'd0);
        wait_idle("t4b_bound", 100);
        #1;
        check("t4b_strobes", 64'(s_cyc.size()), 64'd5);
        check("t4b_done",    64'(config_done),  64'd1);

        // Reset during ISSUE of word 2 of 5.
        apply_reset();
        src_q.delete();
        for (int k = 0; k < 5; k++) push_word(32'h0000_0500 + k, 32'h2000 + k);
        clear_logs();
        pulse_start(5);
        wait_strobes("t5_second", 2, 100);
        reset_n = 1'b0;
        #1;
        check("t5_valid", 64'(config_valid), 64'd0);
        check("t5_busy",  64'(busy),         64'd0);
        check("t5_ready", 64'(in_ready),     64'd0);
        check("t5_addr",  64'(config_addr),  64'hFFFF_FFFF);
        check("t5_data",  64'(config_data),  64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t5_no_strobe", 64'(s_cyc.size()), 64'd2);
        check("t5_idle",      64'(busy),         64'd0);
        check("t5_done",      64'(config_done),  64'd0);

        // Randomised loads: varying length, source duty, stray starts and
        // occasional short supply that forces a timeout.
        for (int n = 0; n < 40; n++) begin
            src_q.delete();
            nw   = $urandom_range(0, 6);
            sup  = ($urandom_range(5) == 0) ? $urandom_range(0, nw) : nw;
            ssum = '0;
            for (int k = 0; k < sup; k++) begin
                ra = $urandom;
                rd = $urandom;
                ssum = ssum + rd;
                push_word(ra, rd);
            end
            valid_pct = $urandom_range(40, 100);
`ifdef CFG_CHECKSUM_EN
            expected_sum = ($urandom_range(1) == 0) ? ssum : ssum + 32'd1;
`endif
            @(negedge clk);
            start     = 1'b1;
            num_words = CW'(nw);
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (!(m_act || busy)) break;
                start     = ($urandom_range(7) == 0);
                num_words = CW'($urandom_range(0, 9));
            end
            start = 1'b0;
            check("rnd_bound", 64'(m_act || busy), 64'd0);
        end

`ifdef CFG_CHECKSUM_EN
        // Checksum match and mismatch.
        apply_reset();
        valid_pct = 100;
        for (int pass = 0; pass < 2; pass++) begin
            src_q.delete();
            push_word(32'h1, 32'h10);
            push_word(32'h2, 32'h20);
            push_word(32'h3, 32'h30);
            expected_sum = (pass == 0) ? 32'h60 : 32'h61;
            pulse_start(3);
            wait_idle("cs_bound", 200);
            #1;
            check("cs_sum",   64'(sum_out),     64'h60);
            check("cs_done",  64'(config_done), 64'd1);
            check("cs_error", 64'(error),       64'(pass));
        end
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
